// File: rtl/scr1_tapc_ctrl_if.sv
// JTAG-side and DR-bank-side signals of the SCR1 TAP controller.
// slave = the TAP controller, master = whatever drives the pins / hosts the DR bank.
interface scr1_tapc_ctrl_if #(
    parameter int IR_WIDTH = 5,
    parameter int DR_CNT   = 3
);
    // The pin side has no handshake: every signal is valid at each TCK posedge.
    logic                tms;
    logic                tdi;
    logic [DR_CNT-1:0]   dr_serial;
    logic                tdo;
    logic                tdo_en;
    logic [DR_CNT-1:0]   fsm_dr_select;
    logic                fsm_dr_capture;
    logic                fsm_dr_shift;
    logic                fsm_dr_update;
    logic                dr_serial_in;
    logic [IR_WIDTH-1:0] ir_value;
    logic                tap_tlr;
    logic [3:0]          fsm_state;

    modport master (
        output tms, tdi, dr_serial,
        input  tdo, tdo_en, fsm_dr_select, fsm_dr_capture, fsm_dr_shift,
               fsm_dr_update, dr_serial_in, ir_value, tap_tlr, fsm_state
    );

    modport slave (
        input  tms, tdi, dr_serial,
        output tdo, tdo_en, fsm_dr_select, fsm_dr_capture, fsm_dr_shift,
               fsm_dr_update, dr_serial_in, ir_value, tap_tlr, fsm_state
    );
endinterface

// File: rtl/scr1_tapc_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, BYPASS bit,
// DR select decode and TDO multiplexing for the SCR1 debug TAP.
module scr1_tapc_ctrl #(
    parameter int SCR1_IR_WIDTH = 5,
    parameter int SCR1_DR_CNT   = 3,
    parameter logic [SCR1_DR_CNT-1:0][SCR1_IR_WIDTH-1:0] SCR1_DR_CODES = {5'h11, 5'h10, 5'h01},
    parameter logic [SCR1_IR_WIDTH-1:0] SCR1_IR_RESET = 5'h01
) (
    input  logic              clk,
    input  logic              rst,
    scr1_tapc_ctrl_if.slave   jtag
);

    localparam logic [3:0] ST_TLR    = 4'd0;
    localparam logic [3:0] ST_RTI    = 4'd1;
    localparam logic [3:0] ST_SEL_DR = 4'd2;
    localparam logic [3:0] ST_CAP_DR = 4'd3;
    localparam logic [3:0] ST_SH_DR  = 4'd4;
    localparam logic [3:0] ST_EX1_DR = 4'd5;
    localparam logic [3:0] ST_PA_DR  = 4'd6;
    localparam logic [3:0] ST_EX2_DR = 4'd7;
    localparam logic [3:0] ST_UPD_DR = 4'd8;
    localparam logic [3:0] ST_SEL_IR = 4'd9;
    localparam logic [3:0] ST_CAP_IR = 4'd10;
    localparam logic [3:0] ST_SH_IR  = 4'd11;
    localparam logic [3:0] ST_EX1_IR = 4'd12;
    localparam logic [3:0] ST_PA_IR  = 4'd13;
    localparam logic [3:0] ST_EX2_IR = 4'd14;
    localparam logic [3:0] ST_UPD_IR = 4'd15;

    logic [3:0]               r_state;
    logic [3:0]               w_next_state;
    logic [SCR1_IR_WIDTH-1:0] r_ir_shift;
    logic [SCR1_IR_WIDTH-1:0] r_ir_value;
    logic                     r_bypass;

    logic                     w_tlr;
    logic                     w_cap_dr;
    logic                     w_sh_dr;
    logic                     w_upd_dr;
    logic                     w_cap_ir;
    logic                     w_sh_ir;
    logic                     w_upd_ir;
    logic [SCR1_IR_WIDTH-1:0] w_ir_value;
    logic [SCR1_DR_CNT-1:0]   w_dr_select;
    logic                     w_bypass_sel;
    logic                     w_tdo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_TLR:    w_next_state = jtag.tms ? ST_TLR    : ST_RTI;
            ST_RTI:    w_next_state = jtag.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: w_next_state = jtag.tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: w_next_state = jtag.tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  w_next_state = jtag.tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: w_next_state = jtag.tms ? ST_UPD_DR : ST_PA_DR;
            ST_PA_DR:  w_next_state = jtag.tms ? ST_EX2_DR : ST_PA_DR;
            ST_EX2_DR: w_next_state = jtag.tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: w_next_state = jtag.tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: w_next_state = jtag.tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: w_next_state = jtag.tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  w_next_state = jtag.tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: w_next_state = jtag.tms ? ST_UPD_IR : ST_PA_IR;
            ST_PA_IR:  w_next_state = jtag.tms ? ST_EX2_IR : ST_PA_IR;
            ST_EX2_IR: w_next_state = jtag.tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: w_next_state = jtag.tms ? ST_SEL_DR : ST_RTI;
            default:   w_next_state = ST_TLR;
        endcase
    end

    // Moore decode only: no path from tms to any strobe.
    always_comb begin
        w_tlr    = (r_state == ST_TLR);
        w_cap_dr = (r_state == ST_CAP_DR);
        w_sh_dr  = (r_state == ST_SH_DR);
        w_upd_dr = (r_state == ST_UPD_DR);
        w_cap_ir = (r_state == ST_CAP_IR);
        w_sh_ir  = (r_state == ST_SH_IR);
        w_upd_ir = (r_state == ST_UPD_IR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_shift <= '0;
        end else if (w_cap_ir) begin
            r_ir_shift <= {{(SCR1_IR_WIDTH-2){1'b0}}, 2'b01};
        end else if (w_sh_ir) begin
            r_ir_shift <= {jtag.tdi, r_ir_shift[SCR1_IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_tlr) begin
            r_ir_value <= SCR1_IR_RESET;
        end else if (w_upd_ir) begin
            r_ir_value <= r_ir_shift;
        end
    end

    // TLR overrides the register so the reset instruction is visible on entry.
    assign w_ir_value = w_tlr ? SCR1_IR_RESET : r_ir_value;

    always_comb begin
        w_dr_select = '0;
        for (int i = 0; i < SCR1_DR_CNT; i++) begin
            w_dr_select[i] = (w_ir_value == SCR1_DR_CODES[i]);
        end
    end

    assign w_bypass_sel = ~|w_dr_select;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bypass <= 1'b0;
        end else if (w_bypass_sel && w_cap_dr) begin
            r_bypass <= 1'b0;
        end else if (w_bypass_sel && w_sh_dr) begin
            r_bypass <= jtag.tdi;
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (w_sh_ir) begin
            w_tdo = r_ir_shift[0];
        end else if (w_sh_dr) begin
            w_tdo = w_bypass_sel ? r_bypass : |(w_dr_select & jtag.dr_serial);
        end
    end

    assign jtag.tdo            = w_tdo;
    assign jtag.tdo_en         = w_sh_dr | w_sh_ir;
    assign jtag.fsm_dr_select  = w_dr_select;
    assign jtag.fsm_dr_capture = w_cap_dr;
    assign jtag.fsm_dr_shift   = w_sh_dr;
    assign jtag.fsm_dr_update  = w_upd_dr;
    assign jtag.dr_serial_in   = jtag.tdi;
    assign jtag.ir_value       = w_ir_value;
    assign jtag.tap_tlr        = w_tlr;
    assign jtag.fsm_state      = r_state;

endmodule

// File: tb/tb_scr1_tapc_ctrl.sv
// Directed bench for scr1_tapc_ctrl: a vector table walks IR and DR scans,
// followed by hand-written TLR-by-TMS and reset-mid-scan sequences.
module tb_scr1_tapc_ctrl;

    localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SDR = 4'd2,  S_CDR = 4'd3;
    localparam logic [3:0] S_SHD = 4'd4,  S_E1D = 4'd5,  S_PAD = 4'd6,  S_E2D = 4'd7;
    localparam logic [3:0] S_UDR = 4'd8,  S_SIR = 4'd9,  S_CIR = 4'd10, S_SHI = 4'd11;
    localparam logic [3:0] S_E1I = 4'd12, S_PAI = 4'd13, S_E2I = 4'd14, S_UIR = 4'd15;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [2:0] dsr;
        logic [3:0] st;
        logic       tdo;
        logic       en;
        logic [2:0] sel;
        logic       cap;
        logic       sh;
        logic       upd;
        logic       tlr;
        logic [4:0] ir;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[43];

    scr1_tapc_ctrl_if #(.IR_WIDTH(5), .DR_CNT(3)) jtag_if ();

    scr1_tapc_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .jtag (jtag_if.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic tms, input logic tdi, input logic [2:0] dsr,
                                input logic [3:0] st, input logic tdo, input logic en,
                                input logic [2:0] sel, input logic cap, input logic sh,
                                input logic upd, input logic tlr, input logic [4:0] ir);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.dsr = dsr; v.st = st; v.tdo = tdo; v.en = en;
        v.sel = sel; v.cap = cap; v.sh = sh; v.upd = upd; v.tlr = tlr; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        jtag_if.tms = t;
        jtag_if.tdi = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, IR scan to 0x10, DR scan on DR1, IR scan to 0x1F, BYPASS scan.
        vecs[0]  = mk(0, 0, 3'b000, S_TLR, 0, 0, 3'b001, 0, 0, 0, 1, 5'h01);
        vecs[1]  = mk(1, 0, 3'b000, S_RTI, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[2]  = mk(1, 0, 3'b000, S_SDR, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[3]  = mk(0, 0, 3'b000, S_SIR, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[4]  = mk(0, 0, 3'b000, S_CIR, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[5]  = mk(0, 0, 3'b000, S_SHI, 1, 1, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[6]  = mk(0, 0, 3'b000, S_SHI, 0, 1, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[7]  = mk(0, 0, 3'b000, S_SHI, 0, 1, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[8]  = mk(0, 0, 3'b000, S_SHI, 0, 1, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[9]  = mk(1, 1, 3'b000, S_SHI, 0, 1, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[10] = mk(1, 0, 3'b000, S_E1I, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[11] = mk(0, 0, 3'b000, S_UIR, 0, 0, 3'b001, 0, 0, 0, 0, 5'h01);
        vecs[12] = mk(1, 0, 3'b000, S_RTI, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[13] = mk(0, 0, 3'b000, S_SDR, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[14] = mk(0, 0, 3'b000, S_CDR, 0, 0, 3'b010, 1, 0, 0, 0, 5'h10);
        vecs[15] = mk(0, 1, 3'b010, S_SHD, 1, 1, 3'b010, 0, 1, 0, 0, 5'h10);
        vecs[16] = mk(0, 0, 3'b101, S_SHD, 0, 1, 3'b010, 0, 1, 0, 0, 5'h10);
        vecs[17] = mk(1, 1, 3'b010, S_SHD, 1, 1, 3'b010, 0, 1, 0, 0, 5'h10);
        vecs[18] = mk(0, 0, 3'b010, S_E1D, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[19] = mk(1, 0, 3'b000, S_PAD, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[20] = mk(1, 0, 3'b000, S_E2D, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[21] = mk(0, 0, 3'b000, S_UDR, 0, 0, 3'b010, 0, 0, 1, 0, 5'h10);
        vecs[22] = mk(1, 0, 3'b000, S_RTI, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[23] = mk(1, 0, 3'b000, S_SDR, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[24] = mk(0, 0, 3'b000, S_SIR, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[25] = mk(0, 0, 3'b000, S_CIR, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[26] = mk(0, 1, 3'b000, S_SHI, 1, 1, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[27] = mk(0, 1, 3'b000, S_SHI, 0, 1, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[28] = mk(0, 1, 3'b000, S_SHI, 0, 1, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[29] = mk(0, 1, 3'b000, S_SHI, 0, 1, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[30] = mk(1, 1, 3'b000, S_SHI, 0, 1, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[31] = mk(1, 0, 3'b000, S_E1I, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[32] = mk(0, 0, 3'b000, S_UIR, 0, 0, 3'b010, 0, 0, 0, 0, 5'h10);
        vecs[33] = mk(1, 0, 3'b000, S_RTI, 0, 0, 3'b000, 0, 0, 0, 0, 5'h1F);
        vecs[34] = mk(0, 0, 3'b000, S_SDR, 0, 0, 3'b000, 0, 0, 0, 0, 5'h1F);
        vecs[35] = mk(0, 0, 3'b111, S_CDR, 0, 0, 3'b000, 1, 0, 0, 0, 5'h1F);
        vecs[36] = mk(0, 1, 3'b111, S_SHD, 0, 1, 3'b000, 0, 1, 0, 0, 5'h1F);
        vecs[37] = mk(0, 0, 3'b111, S_SHD, 1, 1, 3'b000, 0, 1, 0, 0, 5'h1F);
        vecs[38] = mk(0, 1, 3'b111, S_SHD, 0, 1, 3'b000, 0, 1, 0, 0, 5'h1F);
        vecs[39] = mk(1, 1, 3'b111, S_SHD, 1, 1, 3'b000, 0, 1, 0, 0, 5'h1F);
        vecs[40] = mk(1, 0, 3'b000, S_E1D, 0, 0, 3'b000, 0, 0, 0, 0, 5'h1F);
        vecs[41] = mk(0, 0, 3'b000, S_UDR, 0, 0, 3'b000, 0, 0, 1, 0, 5'h1F);
        vecs[42] = mk(1, 0, 3'b000, S_RTI, 0, 0, 3'b000, 0, 0, 0, 0, 5'h1F);

        rst = 1'b1;
        jtag_if.tms = 1'b1;
        jtag_if.tdi = 1'b0;
        jtag_if.dr_serial = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", jtag_if.fsm_state, S_TLR);
        chk("rst_tlr", jtag_if.tap_tlr, 1);
        chk("rst_ir", jtag_if.ir_value, 5'h01);
        chk("rst_sel", jtag_if.fsm_dr_select, 3'b001);
        chk("rst_tdo", jtag_if.tdo, 0);
        chk("rst_tdo_en", jtag_if.tdo_en, 0);
        chk("rst_strobes", {jtag_if.fsm_dr_capture, jtag_if.fsm_dr_shift, jtag_if.fsm_dr_update}, 3'b000);
        rst = 1'b0;

        for (int i = 0; i < 43; i++) begin
            jtag_if.tms = vecs[i].tms;
            jtag_if.tdi = vecs[i].tdi;
            jtag_if.dr_serial = vecs[i].dsr;
            #1;
            chk($sformatf("v%0d_state", i), jtag_if.fsm_state, vecs[i].st);
            chk($sformatf("v%0d_tdo", i), jtag_if.tdo, vecs[i].tdo);
            chk($sformatf("v%0d_tdo_en", i), jtag_if.tdo_en, vecs[i].en);
            chk($sformatf("v%0d_sel", i), jtag_if.fsm_dr_select, vecs[i].sel);
            chk($sformatf("v%0d_cap", i), jtag_if.fsm_dr_capture, vecs[i].cap);
            chk($sformatf("v%0d_shift", i), jtag_if.fsm_dr_shift, vecs[i].sh);
            chk($sformatf("v%0d_upd", i), jtag_if.fsm_dr_update, vecs[i].upd);
            chk($sformatf("v%0d_tlr", i), jtag_if.tap_tlr, vecs[i].tlr);
            chk($sformatf("v%0d_ir", i), jtag_if.ir_value, vecs[i].ir);
            chk($sformatf("v%0d_dr_in", i), jtag_if.dr_serial_in, vecs[i].tdi);
            @(posedge clk);
            #1;
        end
        jtag_if.dr_serial = 3'b000;

        // Five TMS=1 clocks from Shift-DR must land in TLR on the fifth edge.
        step(0, 0);
        step(0, 0);
        chk("tlr5_start", jtag_if.fsm_state, S_SHD);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0);
            chk($sformatf("tlr5_edge%0d", k), jtag_if.tap_tlr, (k == 5) ? 1 : 0);
        end
        step(1, 0);
        chk("tlr5_state", jtag_if.fsm_state, S_TLR);
        chk("tlr5_ir", jtag_if.ir_value, 5'h01);
        chk("tlr5_sel", jtag_if.fsm_dr_select, 3'b001);

        // Reset in the middle of an IR shift aborts it without an update.
        step(0, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 1);
        chk("abort_pre_state", jtag_if.fsm_state, S_SHI);
        chk("abort_pre_en", jtag_if.tdo_en, 1);
        rst = 1'b1;
        step(0, 1);
        chk("abort_state", jtag_if.fsm_state, S_TLR);
        chk("abort_tlr", jtag_if.tap_tlr, 1);
        chk("abort_ir", jtag_if.ir_value, 5'h01);
        chk("abort_tdo_en", jtag_if.tdo_en, 0);
        chk("abort_tdo", jtag_if.tdo, 0);
        rst = 1'b0;
        step(0, 0);
        chk("abort_post_state", jtag_if.fsm_state, S_RTI);
        chk("abort_post_ir", jtag_if.ir_value, 5'h01);
        chk("abort_post_sel", jtag_if.fsm_dr_select, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scr1_tapc_ctrl.md
# scr1_tapc_ctrl

JTAG TAP controller for the SCR1 debug TAP. It runs the IEEE 1149.1 16-state TAP FSM and holds the instruction register and the BYPASS register. From these it produces the select, capture, shift and update strobes that sequence a bank of `scr1_tapc_data_reg` instances, and it multiplexes their serial outputs onto TDO. It sits between the JTAG pins (clocked by TCK) and the data-register bank.

## Interface
- `SCR1_IR_WIDTH`, 5: instruction register width, bits (≥2).
- `SCR1_DR_CNT`, 3: number of external data registers.
- `SCR1_DR_CODES`, {5'h01, 5'h10, 5'h11}: packed array [SCR1_DR_CNT][SCR1_IR_WIDTH]; IR code selecting DR i (entry 0 = IDCODE). Codes are distinct and never all-ones.
- `SCR1_IR_RESET`, 5'h01: IR value after reset or Test-Logic-Reset (TLR).
- `clk`  in  1  TCK; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `tms`  in  1  test mode select.
- `tdi`  in  1  test data in.
- `dr_serial`  in  SCR1_DR_CNT  `dout_serial` of each DR.
- `tdo`  out  1  serial out (combinational mux, see Operation).
- `tdo_en`  out  1  high only in Shift-DR / Shift-IR.
- `fsm_dr_select`  out  SCR1_DR_CNT  one-hot DR select; all-zero selects BYPASS.
- `fsm_dr_capture`, `fsm_dr_shift`, `fsm_dr_update`  out  1 each  high in Capture-DR, Shift-DR and Update-DR respectively.
- `dr_serial_in`  out  1  equals `tdi`; feeds `din_serial` of every DR.
- `ir_value`  out  SCR1_IR_WIDTH  current (updated) instruction.
- `tap_tlr`  out  1  high in the TLR state (reset for downstream `rst_n_sync`, inverted externally).

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR. Transitions follow IEEE 1149.1 exactly on `tms` at each posedge.
- Transitions with tms=1:
  - TLR→TLR; RTI→SEL_DR; SEL_DR→SEL_IR; SEL_IR→TLR.
  - CAP→EX1; SH→EX1; EX1→UPD; PA→EX2; EX2→UPD; UPD→SEL_DR (DR and IR branches alike).
- Transitions with tms=0:
  - TLR→RTI; RTI→RTI; SEL_DR→CAP_DR; SEL_IR→CAP_IR.
  - CAP→SH; SH→SH; EX1→PA; PA→PA; EX2→SH; UPD→RTI.
- Any state reaches TLR after 5 consecutive tms=1 clocks.
- IR shift register (`ir_shift`):
  - CAP_IR: loads {'0, 2'b01}.
  - SH_IR: loads {tdi, ir_shift[W-1:1]}.
  - UPD_IR: at the posedge leaving UPD_IR, `ir_value <= ir_shift`.
- In TLR, `ir_value` is forced to SCR1_IR_RESET.
- DR decode:
  - `fsm_dr_select[i] = (ir_value == SCR1_DR_CODES[i])`.
  - Any other code (including all-ones) selects BYPASS: `fsm_dr_select` = 0.
  - Select is independent of FSM state.
- BYPASS:
  - 1-bit flop; cleared in CAP_DR when bypass is selected.
  - Loads `tdi` in SH_DR when bypass is selected.
- TDO mux:
  - SH_IR: `ir_shift[0]`.
  - SH_DR: `dr_serial[i]` of the selected DR, else the bypass bit.
  - Otherwise: 0.
- Negedge retiming of TDO for the pin is outside this block.
- Reset (`rst`=1 at a posedge): state=TLR, `ir_shift`=0, `ir_value`=SCR1_IR_RESET, bypass=0.
  - Outputs after reset: `tap_tlr`=1, strobes=0, `tdo_en`=0, `tdo`=0.
  - `fsm_dr_select` = decode of SCR1_IR_RESET (IDCODE).
- Reset mid-scan aborts the scan; `ir_value` is not updated from a partial shift.
- `rst` has priority over `tms`.

## Timing
- Strobes and `tdo_en` are Moore outputs decoded from registered state; no combinational path from `tms`.
- DR capture and shift take effect at the posedge during which the FSM is in CAP_DR or SH_DR.
- `fsm_dr_update` is high for the whole UPD_DR cycle, so a DR shadow register samples it at the following negedge.
- A new instruction drives `fsm_dr_select` starting the cycle after UPD_IR; an N-bit IR scan takes N SH_IR cycles.
- A SH_DR/SH_IR cycle in which `tms`=1 (exit) still shifts.
- `tdo` is combinational from state, `ir_shift`, the bypass bit and `dr_serial`.
- Latency from `tms` to state is one clock.

## Test plan
- Reset, then tms=0 for 1 clk → state RTI, `tap_tlr`=0, `ir_value`=5'h01, `fsm_dr_select`=3'b001.
- From SH_DR, tms=1 for 5 clks → TLR on the 5th edge; `ir_value` returns to 5'h01 even after an earlier load of 5'h10.
- IR scan:
  - Stimulus: tms 1,1,0,0 (→SH_IR), shift tdi LSB-first 0,0,0,0,1 with tms=1 on the last bit, then tms=1,0.
  - Response: `tdo` during shift = 1,0,0,0,0 (captured 5'b00001); `ir_value`=5'h10; `fsm_dr_select`=3'b010 from the cycle after UPD_IR.
- DR scan with DR1 selected:
  - `fsm_dr_capture` is high exactly one cycle (CAP_DR).
  - `fsm_dr_shift` is high for each SH_DR cycle.
  - `fsm_dr_update` is high exactly one cycle (UPD_DR).
  - `tdo` tracks `dr_serial[1]`; `dr_serial_in` tracks `tdi`.
- Load IR=5'h1F (BYPASS), shift DR with tdi 1,0,1,1 → `tdo` = 0,1,0,1 (one-bit delay after the captured 0); `fsm_dr_select`=0.
- Assert `rst` in SH_IR after 2 bits → next cycle TLR, `ir_value`=5'h01, `tdo_en`=0; no UPD_IR occurs.
